// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds one byte at a time from four requesters
// into a single UART transmitter, with a busy-handshake timeout.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              uart_start,
    output logic [7:0]        uart_data,
    input  logic              uart_busy,
    output logic [1:0]        grant_id,
    output logic              active,
    output logic              err_timeout,
    output logic [15:0]       tx_count
);

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [TW-1:0]   to_cnt;
    logic [1:0]      sel_idx;
    logic            sel_valid;

    // Walk the ring from the far end back toward rr_ptr so the nearest set bit wins.
    always_comb begin
        sel_idx   = 2'd0;
        sel_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_ptr + 2'(k)]) begin
                sel_idx   = rr_ptr + 2'(k);
                sel_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            to_cnt      <= '0;
            ack         <= '0;
            uart_start  <= 1'b0;
            uart_data   <= 8'd0;
            grant_id    <= 2'd0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
            tx_count    <= 16'd0;
        end else begin
            ack        <= '0;
            uart_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && !uart_busy && sel_valid) begin
                        rr_ptr         <= sel_idx + 2'd1;
                        grant_id       <= sel_idx;
                        uart_data      <= req_data[8*sel_idx +: 8];
                        ack[sel_idx]   <= 1'b1;
                        uart_start     <= 1'b1;
                        tx_count       <= tx_count + 16'd1;
                        active         <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    to_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        // The transmitter never acknowledged; give up on this frame.
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table for grant decisions plus
// hand-written frame sequences against a behavioural UART model.
module tb_uart_tx_sched;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;
    logic [15:0] tx_count;

    logic        useModel;
    logic        manBusy;
    logic        modelBusy;
    logic        txLine;
    logic [9:0]  shreg;
    int          clkCnt;
    int          bitCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    uart_tx_sched #(.NREQ(4), .BUSY_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .ack(ack), .uart_start(uart_start), .uart_data(uart_data),
        .uart_busy(uart_busy), .grant_id(grant_id), .active(active),
        .err_timeout(err_timeout), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    assign uart_busy = useModel ? modelBusy : manBusy;

    // Behavioural 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
    always @(posedge clk) begin
        if (rst || !useModel) begin
            modelBusy <= 1'b0;
            txLine    <= 1'b1;
            clkCnt    <= 0;
            bitCnt    <= 0;
        end else if (!modelBusy) begin
            if (uart_start) begin
                shreg     <= {1'b1, uart_data, 1'b0};
                modelBusy <= 1'b1;
                txLine    <= 1'b0;
                clkCnt    <= 0;
                bitCnt    <= 0;
            end
        end else if (clkCnt == CPB - 1) begin
            clkCnt <= 0;
            if (bitCnt == 9) begin
                modelBusy <= 1'b0;
                txLine    <= 1'b1;
            end else begin
                bitCnt <= bitCnt + 1;
                txLine <= shreg[bitCnt + 1];
            end
        end else begin
            clkCnt <= clkCnt + 1;
        end
    end

    typedef struct {
        logic        en;
        logic        busy;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  expAck;
        logic [7:0]  expData;
        logic [1:0]  expGrant;
        logic [15:0] expCount;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        en       = v.en;
        manBusy  = v.busy;
        req      = v.req;
        req_data = v.data;
        step();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        en       = 1'b0;
        req      = 4'd0;
        req_data = 32'd0;
        manBusy  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ack"}, 32'(ack), 0);
        checkOutput({tag, " uart_start"}, 32'(uart_start), 0);
        checkOutput({tag, " uart_data"}, 32'(uart_data), 0);
        checkOutput({tag, " grant_id"}, 32'(grant_id), 0);
        checkOutput({tag, " active"}, 32'(active), 0);
        checkOutput({tag, " err_timeout"}, 32'(err_timeout), 0);
        checkOutput({tag, " tx_count"}, 32'(tx_count), 0);
    endtask

    task automatic waitStart(input string name, input int bound);
        int n = 0;
        while (uart_start !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        if (uart_start !== 1'b1) checkOutput({name, " start timeout"}, 32'(uart_start), 1);
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n = 0;
        while (active !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        checkOutput({name, " active fell"}, 32'(active), 0);
    endtask

    task automatic receiveByte(output logic [7:0] b, output logic ok);
        int n = 0;
        b  = 8'd0;
        ok = 1'b0;
        while (txLine !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        if (txLine === 1'b0) begin
            repeat (CPB / 2) step();
            ok = (txLine === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) step();
                b[i] = txLine;
            end
        end
    endtask

    // Drives a granted frame through WAIT_BUSY/WAIT_DONE with the manual busy line.
    task automatic finishFrame(input string tag);
        req     = 4'd0;
        manBusy = 1'b1;
        step();
        checkOutput({tag, " ack cleared"}, 32'(ack), 0);
        checkOutput({tag, " start cleared"}, 32'(uart_start), 0);
        checkOutput({tag, " active in frame"}, 32'(active), 1);
        step();
        manBusy = 1'b0;
        step();
        checkOutput({tag, " back idle"}, 32'(active), 0);
    endtask

    initial begin
        logic [7:0] rxByte;
        logic       rxOk;
        logic [7:0] bytes4 [4];
        int         seen;
        int         n;

        useModel = 1'b0;
        manBusy  = 1'b0;
        rst      = 1'b1;

        vecs[0]  = '{1'b0, 1'b0, 4'b0001, 32'h44332211, 4'b0000, 8'h00, 2'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'b0001, 32'h44332211, 4'b0000, 8'h00, 2'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 32'h44332211, 4'b0000, 8'h00, 2'd0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'b0100, 32'h00A50000, 4'b0100, 8'hA5, 2'd2, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 4'b1001, 32'hD4C3B2A1, 4'b1000, 8'hD4, 2'd3, 16'd2};
        vecs[5]  = '{1'b1, 1'b0, 4'b1001, 32'hD4C3B2A1, 4'b0001, 8'hA1, 2'd0, 16'd3};
        vecs[6]  = '{1'b1, 1'b0, 4'b1001, 32'hD4C3B2A1, 4'b1000, 8'hD4, 2'd3, 16'd4};
        vecs[7]  = '{1'b1, 1'b0, 4'b0110, 32'h44332211, 4'b0010, 8'h22, 2'd1, 16'd5};
        vecs[8]  = '{1'b1, 1'b0, 4'b0011, 32'h44332211, 4'b0001, 8'h11, 2'd0, 16'd6};
        vecs[9]  = '{1'b1, 1'b0, 4'b1111, 32'h88776655, 4'b0010, 8'h66, 2'd1, 16'd7};
        vecs[10] = '{1'b0, 1'b0, 4'b1111, 32'h88776655, 4'b0000, 8'h66, 2'd1, 16'd7};
        vecs[11] = '{1'b1, 1'b1, 4'b1111, 32'h88776655, 4'b0000, 8'h66, 2'd1, 16'd7};
        vecs[12] = '{1'b1, 1'b0, 4'b1111, 32'h88776655, 4'b0100, 8'h77, 2'd2, 16'd8};

        doReset();
        checkResetValues("reset");

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i]);
            checkOutput({tag, " ack"}, 32'(ack), 32'(vecs[i].expAck));
            checkOutput({tag, " uart_start"}, 32'(uart_start), 32'(vecs[i].expAck != 4'd0));
            checkOutput({tag, " uart_data"}, 32'(uart_data), 32'(vecs[i].expData));
            checkOutput({tag, " grant_id"}, 32'(grant_id), 32'(vecs[i].expGrant));
            checkOutput({tag, " tx_count"}, 32'(tx_count), 32'(vecs[i].expCount));
            checkOutput({tag, " active"}, 32'(active), 32'(vecs[i].expAck != 4'd0));
            if (vecs[i].expAck != 4'd0) finishFrame(tag);
            manBusy = 1'b0;
        end

        // Single request through the UART model, byte checked on the serial line.
        doReset();
        useModel = 1'b1;
        en       = 1'b1;
        req      = 4'b0100;
        req_data = 32'h00A50000;
        waitStart("single", 10);
        checkOutput("single ack", 32'(ack), 32'b0100);
        checkOutput("single data", 32'(uart_data), 32'hA5);
        checkOutput("single grant", 32'(grant_id), 2);
        checkOutput("single count", 32'(tx_count), 1);
        req = 4'd0;
        step();
        checkOutput("single start pulse width", 32'(uart_start), 0);
        checkOutput("single ack pulse width", 32'(ack), 0);
        receiveByte(rxByte, rxOk);
        checkOutput("single rx start bit", 32'(rxOk), 1);
        checkOutput("single rx byte", 32'(rxByte), 32'hA5);
        waitIdle("single", 400);
        checkOutput("single busy low at idle", 32'(uart_busy), 0);
        checkOutput("single final count", 32'(tx_count), 1);

        // Four requesters held together are served 0,1,2,3.
        doReset();
        bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
        en       = 1'b1;
        req      = 4'b1111;
        req_data = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("rr4 frame%0d", i);
            waitStart(tag, 400);
            checkOutput({tag, " grant"}, 32'(grant_id), i);
            checkOutput({tag, " ack"}, 32'(ack), 32'(1) << i);
            checkOutput({tag, " data"}, 32'(uart_data), 32'(bytes4[i]));
            checkOutput({tag, " no busy overlap"}, 32'(uart_busy), 0);
            req[i] = 1'b0;
            step();
        end
        waitIdle("rr4", 400);
        checkOutput("rr4 count", 32'(tx_count), 4);

        // Transmitter that never raises busy.
        doReset();
        useModel = 1'b0;
        manBusy  = 1'b0;
        en       = 1'b1;
        req      = 4'b0001;
        step();
        checkOutput("timeout grant ack", 32'(ack), 32'b0001);
        req = 4'd0;
        repeat (4) step();
        checkOutput("timeout not yet err", 32'(err_timeout), 0);
        checkOutput("timeout still active", 32'(active), 1);
        step();
        checkOutput("timeout err set", 32'(err_timeout), 1);
        checkOutput("timeout back idle", 32'(active), 0);
        req = 4'b0010;
        step();
        checkOutput("timeout regrant ack", 32'(ack), 32'b0010);
        checkOutput("timeout regrant count", 32'(tx_count), 2);
        req = 4'd0;
        repeat (8) step();
        checkOutput("timeout err sticky", 32'(err_timeout), 1);
        doReset();
        checkOutput("timeout err cleared by rst", 32'(err_timeout), 0);

        // Enable low blocks grants but never aborts a frame in progress.
        useModel = 1'b1;
        en       = 1'b0;
        req      = 4'b0001;
        req_data = 32'h000000C3;
        seen     = 0;
        repeat (5) begin
            step();
            if (ack != 4'd0) seen++;
        end
        checkOutput("en low no ack", seen, 0);
        en = 1'b1;
        waitStart("en", 10);
        checkOutput("en grant ack", 32'(ack), 32'b0001);
        n = 0;
        while (uart_busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput("en uart busy rose", 32'(uart_busy), 1);
        step();
        en = 1'b0;
        waitIdle("en frame complete", 400);
        seen = 0;
        repeat (20) begin
            step();
            if (uart_start) seen++;
        end
        checkOutput("en low no restart", seen, 0);
        en = 1'b1;
        waitStart("en resume", 10);
        checkOutput("en resume grant", 32'(grant_id), 0);
        checkOutput("en resume count", 32'(tx_count), 2);
        req = 4'd0;
        waitIdle("en resume", 400);

        // Reset in the middle of the data bits.
        doReset();
        en       = 1'b1;
        req      = 4'b0010;
        req_data = 32'h00005A00;
        waitStart("midrst", 10);
        req = 4'd0;
        repeat (40) step();
        checkOutput("midrst active before rst", 32'(active), 1);
        rst = 1'b1;
        step();
        checkResetValues("midrst");
        rst = 1'b0;
        req = 4'b1010;
        step();
        checkOutput("midrst regrant ack", 32'(ack), 32'b0010);
        checkOutput("midrst regrant id", 32'(grant_id), 1);
        checkOutput("midrst regrant count", 32'(tx_count), 1);
        req = 4'd0;
        waitIdle("midrst", 400);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 for this revision.
REQ-002 Parameter BUSY_TIMEOUT, default 4, max cycles to wait for uart_busy to rise after a start pulse.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  global enable; low blocks new grants and lets an in-flight frame complete.
REQ-006 req  input  4  per-requester transmit request; bit i belongs to requester i.
REQ-007 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-008 ack  output  4  one-cycle pulse on bit i when requester i's byte is accepted.
REQ-009 uart_start  output  1  start pulse to the UART transmitter.
REQ-010 uart_data  output  8  byte presented to the UART transmitter.
REQ-011 uart_busy  input  1  busy flag from the UART transmitter.
REQ-012 grant_id  output  2  index of the last granted requester.
REQ-013 active  output  1  high while any state other than IDLE is occupied.
REQ-014 err_timeout  output  1  sticky flag: uart_busy failed to rise within BUSY_TIMEOUT cycles.
REQ-015 tx_count  output  16  number of accepted bytes; wraps modulo 2^16.

Function
REQ-016 Outputs are registered and the FSM states are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE, a grant is made when en=1, uart_busy=0 and req!=0; otherwise the FSM stays in IDLE.
REQ-018 Arbitration is round-robin: search starts at pointer rr_ptr and ascends modulo 4; the first set req bit wins.
REQ-019 On a grant to i, at the edge: rr_ptr <= (i+1) mod 4; grant_id <= i; uart_data <= req_data byte i; ack[i] <= 1; uart_start <= 1; tx_count <= tx_count+1; state <= LAUNCH.
REQ-020 ack and uart_start are therefore high together for exactly one cycle, the cycle after the grant decision.
REQ-021 In LAUNCH, ack and uart_start clear at the next edge and the FSM moves to WAIT_BUSY with the timeout counter at 0.
REQ-022 uart_data holds its value until the next grant.
REQ-023 In WAIT_BUSY, uart_busy=1 moves the FSM to WAIT_DONE.
REQ-024 In WAIT_BUSY, uart_busy=0 increments the timeout counter.
REQ-025 When the timeout counter reaches BUSY_TIMEOUT-1 with uart_busy still 0, err_timeout is set and the FSM returns to IDLE.
REQ-026 In WAIT_DONE, uart_busy=0 returns the FSM to IDLE, and a new grant may be made in the following IDLE cycle.
REQ-027 Requester protocol: hold req and req_data stable until ack; req still high in the cycle after ack is a new request.
REQ-028 req bits that rise while the FSM is outside IDLE are ignored until IDLE and are never lost if held.
REQ-029 en falling in LAUNCH, WAIT_BUSY or WAIT_DONE does not abort the frame; only the next grant is blocked.
REQ-030 uart_busy=1 in IDLE (for example, a frame launched externally) blocks grants until it falls.
REQ-031 Simultaneous requests are served one per frame in round-robin order, so no requester waits more than 3 frames while held.
REQ-032 err_timeout clears only on rst.
REQ-033 tx_count wraps from 16'hFFFF to 0.

Reset
REQ-034 While rst=1 at an edge: state=IDLE, ack=0, uart_start=0, uart_data=0, grant_id=0, rr_ptr=0, active=0, err_timeout=0, tx_count=0.
REQ-035 rst asserted mid-frame abandons the frame without issuing any further uart_start, and the first grant after reset release starts the search from requester 0.

Verification
REQ-036 Single request: req=4'b0100, req_data byte2=8'hA5, UART (CLK_PER_BIT=16) connected -> ack=4'b0100 and uart_start for 1 cycle, uart_data=8'hA5, grant_id=2, tx line carries 0xA5 LSB-first, active falls after busy falls, tx_count=1.
REQ-037 All four requesters held with bytes 8'h11/22/33/44 -> four frames in order 0,1,2,3, each ack exactly once, no overlap of uart_start with uart_busy=1.
REQ-038 After a grant to requester 3 with req=4'b1001 held -> the next grant goes to 0, then 3, alternating.
REQ-039 UART stub that never raises busy -> err_timeout=1 four cycles into WAIT_BUSY, FSM back in IDLE, next request still granted.
REQ-040 en=0 with req=4'b0001 -> no ack; en driven low during WAIT_DONE -> frame completes and no new uart_start is issued until en=1.
REQ-041 rst pulsed during data-bit transmission -> all outputs at reset values the next cycle, tx_count=0, and a subsequent req=4'b1000 is granted normally.
